// File: rtl/hidden_layer_mac.sv
// Serial-MAC hidden layer: buffers N_IN features, computes N_HID saturated neurons, holds them with valid/ready.
// Optional per-neuron bias is enabled by defining HIDDEN_BIAS_EN.
module hidden_layer_mac #(
  parameter  int N_IN      = 8,
  parameter  int N_HID     = 5,
  parameter  int DATA_W    = 10,
  parameter  int FRAC_BITS = 8,
  parameter  int ACC_W     = 24,
  localparam int N_W       = N_IN * N_HID,
  localparam int W_ADDR_W  = $clog2(N_W),
  localparam int H_W       = $clog2(N_HID),
  localparam int I_W       = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    w_we,
  input  logic [W_ADDR_W-1:0]     w_addr,
  input  logic [DATA_W-1:0]       w_data,
`ifdef HIDDEN_BIAS_EN
  input  logic                    bias_we,
  input  logic [H_W-1:0]          bias_addr,
  input  logic [DATA_W-1:0]       bias_data,
`endif
  output logic                    busy,
  output logic                    hid_valid,
  input  logic                    hid_ready,
  output logic [N_HID*DATA_W-1:0] hid_val
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  state_t state, state_nxt;

  logic        [DATA_W-1:0]   feat  [N_IN];
  logic signed [DATA_W-1:0]   w_mem [N_W];
  logic        [I_W-1:0]      i_cnt;
  logic        [H_W-1:0]      h_cnt;
  logic signed [ACC_W-1:0]    acc;

  logic                       last_feat, last_hid, in_hs, out_hs;
  logic        [W_ADDR_W-1:0] w_idx;
  logic signed [DATA_W:0]     feat_ext;
  logic signed [DATA_W-1:0]   w_cur;
  logic signed [2*DATA_W:0]   prod;
  logic signed [ACC_W-1:0]    sum, scaled, acc_init;
  logic        [DATA_W-1:0]   sat_val;

  assign last_feat = (i_cnt == I_W'(N_IN - 1));
  assign last_hid  = (h_cnt == H_W'(N_HID - 1));
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = hid_valid & hid_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = ~rst;
        if (in_hs && last_feat) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_feat && last_hid) state_nxt = OUT;
      end
      OUT: begin
        if (out_hs) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // One product per cycle; weights walk h-major so the address is just h*N_IN+i.
  assign w_idx    = W_ADDR_W'(h_cnt) * W_ADDR_W'(N_IN) + W_ADDR_W'(i_cnt);
  assign feat_ext = {1'b0, feat[i_cnt]};
  assign w_cur    = w_mem[w_idx];
  assign prod     = feat_ext * w_cur;
  assign sum      = acc + {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
  assign scaled   = sum >>> FRAC_BITS;

  always_comb begin
    sat_val = scaled[DATA_W-1:0];
    if (scaled < 0)            sat_val = '0;
    else if (scaled > SAT_MAX) sat_val = '1;
  end

`ifdef HIDDEN_BIAS_EN
  logic signed [DATA_W-1:0] bias [N_HID];
  logic        [H_W-1:0]    h_init;

  // Accumulator is preloaded for the neuron about to start: 0 from LOAD, h+1 mid-compute.
  assign h_init = (state == COMPUTE) ? h_cnt + 1'b1 : '0;

  always_comb begin
    acc_init = '0;
    if (h_init < H_W'(N_HID))
      acc_init = {{(ACC_W-DATA_W){bias[h_init][DATA_W-1]}}, bias[h_init]} <<< FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_HID; k++) bias[k] <= '0;
    end else if (bias_we && !busy && bias_addr < H_W'(N_HID)) begin
      bias[bias_addr] <= bias_data;
    end
  end
`else
  assign acc_init = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) feat[k]  <= '0;
      for (int k = 0; k < N_W; k++)  w_mem[k] <= '0;
      i_cnt     <= '0;
      h_cnt     <= '0;
      acc       <= '0;
      hid_val   <= '0;
      hid_valid <= 1'b0;
    end else begin
      if (w_we && !busy && w_addr < W_ADDR_W'(N_W))
        w_mem[w_addr] <= w_data;
      case (state)
        LOAD: begin
          if (in_hs) begin
            feat[i_cnt] <= in_data;
            if (last_feat) begin
              i_cnt <= '0;
              h_cnt <= '0;
              acc   <= acc_init;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (last_feat) begin
            hid_val[h_cnt*DATA_W +: DATA_W] <= sat_val;
            acc   <= acc_init;
            i_cnt <= '0;
            h_cnt <= last_hid ? '0 : h_cnt + 1'b1;
          end else begin
            acc   <= sum;
            i_cnt <= i_cnt + 1'b1;
          end
        end
        OUT: begin
          hid_valid <= ~out_hs;
        end
        default: hid_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Randomised and directed bench for hidden_layer_mac against an arithmetic reference model.
module tb_hidden_layer_mac;
  localparam int N_IN  = 8;
  localparam int N_HID = 5;
  localparam int DW    = 10;
  localparam int NW    = N_IN * N_HID;
  localparam int AW    = $clog2(NW);
  localparam int HW    = $clog2(N_HID);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [DW-1:0]      in_data;
  logic               w_we;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data;
  logic               busy, hid_valid, hid_ready;
  logic [N_HID*DW-1:0] hid_val;
`ifdef HIDDEN_BIAS_EN
  logic               bias_we;
  logic [HW-1:0]      bias_addr;
  logic [DW-1:0]      bias_data;
`endif

  int n_vec = 0;
  int n_err = 0;
  int feat_m [N_IN];
  int w_m    [NW];
  int bias_m [N_HID];
  int exp_h  [N_HID];
  int lat;

  always #5 clk = ~clk;

  hidden_layer_mac dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
`ifdef HIDDEN_BIAS_EN
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
`endif
    .busy(busy), .hid_valid(hid_valid), .hid_ready(hid_ready), .hid_val(hid_val)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each neuron: (bias*2^8 + sum feat*w) >> 8, clamped to [0, 1023].
  function automatic void model();
    for (int h = 0; h < N_HID; h++) begin
      longint a = longint'(bias_m[h]) * 256;
      longint s;
      for (int i = 0; i < N_IN; i++) a += longint'(feat_m[i]) * longint'(w_m[h*N_IN+i]);
      s = a >>> 8;
      if (s < 0) s = 0;
      if (s > 1023) s = 1023;
      exp_h[h] = int'(s);
    end
  endfunction

  task automatic write_w(input int a, input int d);
    w_we = 1'b1; w_addr = AW'(a); w_data = DW'(d);
    @(negedge clk);
    w_we = 1'b0;
  endtask

`ifdef HIDDEN_BIAS_EN
  task automatic write_b(input int a, input int d);
    bias_we = 1'b1; bias_addr = HW'(a); bias_data = DW'(d);
    @(negedge clk);
    bias_we = 1'b0;
  endtask
`endif

  task automatic load_weights();
    for (int a = 0; a < NW; a++) write_w(a, w_m[a]);
  endtask

  task automatic send_sample();
    for (int i = 0; i < N_IN; i++) begin
      int t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) check("in_ready_timeout", 0, 1);
      in_valid = 1'b1; in_data = DW'(feat_m[i]);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (!hid_valid && l < 200) begin @(negedge clk); l++; end
  endtask

  task automatic check_result(input string tag);
    model();
    for (int h = 0; h < N_HID; h++) check(tag, longint'(hid_val[h*DW +: DW]), exp_h[h]);
  endtask

  task automatic run_sample(input string tag);
    send_sample();
    wait_result(lat);
    check({tag, "_lat"}, lat, 41);
    check_result(tag);
    @(negedge clk);
  endtask

  task automatic set_all(input int wv, input int fv);
    for (int a = 0; a < NW; a++) w_m[a] = wv;
    for (int i = 0; i < N_IN; i++) feat_m[i] = fv;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    hid_ready = 1'b1;
`ifdef HIDDEN_BIAS_EN
    bias_we = 1'b0; bias_addr = '0; bias_data = '0;
`endif
    for (int h = 0; h < N_HID; h++) bias_m[h] = 0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_after", in_ready, 1);
    check("rst_hid_valid", hid_valid, 0);
    check("rst_hid_val", hid_val, 0);
    check("rst_busy", busy, 0);

    // unity weights
    set_all(256, 100);
    load_weights();
    run_sample("t1");
    check("t1_in_ready", in_ready, 1);

    // saturate high, clamp low
    set_all(511, 1023);
    load_weights();
    run_sample("t2_sat");
    set_all(-256, 0);
    for (int i = 0; i < N_IN; i++) feat_m[i] = $urandom_range(1, 1023);
    load_weights();
    run_sample("t2_clamp");

    // downstream stall holds the result
    set_all(256, 100);
    load_weights();
    hid_ready = 1'b0;
    send_sample();
    wait_result(lat);
    check("t3_lat", lat, 41);
    model();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_hold_valid", hid_valid, 1);
      check("t3_hold_in_ready", in_ready, 0);
      check("t3_hold_val0", longint'(hid_val[0 +: DW]), exp_h[0]);
    end
    hid_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", hid_valid, 0);
    check("t3_in_ready", in_ready, 1);

    // weight write while busy is dropped, in LOAD it lands
    send_sample();
    check("t4_busy", busy, 1);
    write_w(0, -256);
    wait_result(lat);
    check_result("t4_busy_write");
    @(negedge clk);
    write_w(0, -256);
    w_m[0] = -256;
    write_w(45, 300);
    run_sample("t4_load_write");

    // reset mid-compute discards everything including weights
    send_sample();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_hid_valid", hid_valid, 0);
    check("t5_hid_val", hid_val, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    set_all(0, 0);
    for (int i = 0; i < N_IN; i++) feat_m[i] = $urandom_range(0, 1023);
    run_sample("t5_cleared");
    set_all(256, 77);
    load_weights();
    run_sample("t5_fresh");

    // randomised samples with random downstream stalls
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < NW; a++) w_m[a] = int'($urandom_range(0, 1023)) - 512;
      for (int i = 0; i < N_IN; i++) feat_m[i] = $urandom_range(0, 1023);
`ifdef HIDDEN_BIAS_EN
      for (int h = 0; h < N_HID; h++) begin
        bias_m[h] = int'($urandom_range(0, 1023)) - 512;
        write_b(h, bias_m[h]);
      end
`endif
      load_weights();
      hid_ready = 1'($urandom_range(0, 1));
      send_sample();
      wait_result(lat);
      check("rnd_lat", lat, 41);
      check_result("rnd");
      if (!hid_ready) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check_result("rnd_stall");
        hid_ready = 1'b1;
      end
      @(negedge clk);
      check("rnd_in_ready", in_ready, 1);
    end

`ifdef HIDDEN_BIAS_EN
    // bias on one neuron
    set_all(256, 100);
    load_weights();
    for (int h = 0; h < N_HID; h++) begin
      bias_m[h] = (h == 2) ? -50 : 0;
      write_b(h, bias_m[h]);
    end
    run_sample("t6_bias");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
